dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the core load/store path (port C)
//  and a memory loader/debug requester (port L). Picks one owner per cycle,

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core (C) vs loader/debug (L), round-robin on ties,
// with bounded loader lock bursts followed by a forced one-cycle core window.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  c_req_i,
    input  logic                  c_we_i,
    input  logic [ADDR_WIDTH-1:0] c_addr_i,
    input  logic [DATA_WIDTH-1:0] c_wdata_i,
    input  logic [CTRL_WIDTH-1:0] c_ctrl_i,
    output logic                  c_gnt_o,
    output logic [DATA_WIDTH-1:0] c_rdata_o,
    output logic                  c_stall_o,
    input  logic                  l_req_i,
    input  logic                  l_lock_i,
    input  logic                  l_we_i,
    input  logic [ADDR_WIDTH-1:0] l_addr_i,
    input  logic [DATA_WIDTH-1:0] l_wdata_i,
    input  logic [CTRL_WIDTH-1:0] l_ctrl_i,
    output logic                  l_gnt_o,
    output logic [DATA_WIDTH-1:0] l_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [CTRL_WIDTH-1:0] mem_ctrl_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT = $clog2(MAX_BURST + 1);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOCKED  = 2'd1;
    localparam logic [1:0] ST_BACKOFF = 2'd2;
    localparam logic [CNT-1:0] CNT_MAX  = CNT'(MAX_BURST);
    localparam logic [CNT-1:0] CNT_ONE  = CNT'(1);
    localparam logic [CNT-1:0] CNT_ZERO = CNT'(0);

    logic [1:0]     fsm_q, fsm_d;
    logic           last_l_q, last_l_d;
    logic [CNT-1:0] cnt_q, cnt_d;
    logic           c_req_s, l_req_s, c_win_s, l_win_s;

    // Round-robin pick: L wins if alone, or on a tie when C had the last grant.
    function automatic logic rr_pick_l(input logic c_req, input logic l_req, input logic last_l);
        return l_req & (~c_req | ~last_l);
    endfunction

    // Requests are masked during reset so every grant-derived output reads zero.
    assign c_req_s = c_req_i & ~rst_i;
    assign l_req_s = l_req_i & ~rst_i;

    // Grant decision and next-state for the lock FSM, owner history and burst count.
    always_comb begin
        c_win_s = 1'b0;
        l_win_s = 1'b0;
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                l_win_s = rr_pick_l(c_req_s, l_req_s, last_l_q);
                c_win_s = c_req_s & ~l_win_s;
                if (l_win_s & l_lock_i) begin
                    fsm_d = ST_LOCKED;
                    cnt_d = CNT_ONE;
                end else begin
                    fsm_d = ST_IDLE;
                    cnt_d = CNT_ZERO;
                end
            end
            ST_LOCKED: begin
                if (l_req_s & l_lock_i) begin
                    if (cnt_q < CNT_MAX) begin
                        l_win_s = 1'b1;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        c_win_s = c_req_s;
                        fsm_d   = ST_BACKOFF;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    // Lock released: plain arbitration, and no new lock from this cycle.
                    l_win_s = rr_pick_l(c_req_s, l_req_s, last_l_q);
                    c_win_s = c_req_s & ~l_win_s;
                    fsm_d   = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_BACKOFF: begin
                c_win_s = c_req_s;
                fsm_d   = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                fsm_d = ST_IDLE;
                cnt_d = CNT_ZERO;
            end
        endcase
        if (l_win_s) begin
            last_l_d = 1'b1;
        end else if (c_win_s) begin
            last_l_d = 1'b0;
        end else begin
            last_l_d = last_l_q;
        end
    end

    // Memory-side mux: winner's request, all zero when nobody owns the port.
    always_comb begin
        if (l_win_s) begin
            mem_addr_o  = l_addr_i;
            mem_wdata_o = l_wdata_i;
            mem_ctrl_o  = l_ctrl_i;
            mem_we_o    = l_we_i;
        end else if (c_win_s) begin
            mem_addr_o  = c_addr_i;
            mem_wdata_o = c_wdata_i;
            mem_ctrl_o  = c_ctrl_i;
            mem_we_o    = c_we_i;
        end else begin
            mem_addr_o  = {ADDR_WIDTH{1'b0}};
            mem_wdata_o = {DATA_WIDTH{1'b0}};
            mem_ctrl_o  = {CTRL_WIDTH{1'b0}};
            mem_we_o    = 1'b0;
        end
    end

    assign c_gnt_o   = c_win_s;
    assign l_gnt_o   = l_win_s;
    assign c_stall_o = c_req_s & ~c_win_s;
    assign c_rdata_o = mem_rdata_i;
    assign l_rdata_o = mem_rdata_i;

    // Arbiter state; reset leaves L as last owner so the first tie goes to C.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q    <= ST_IDLE;
            last_l_q <= 1'b1;
            cnt_q    <= CNT_ZERO;
        end else begin
            fsm_q    <= fsm_d;
            last_l_q <= last_l_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver pushes hand-computed expectations,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        cg;
        logic        lg;
        logic        st;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_lock = 1'b0, l_we = 1'b0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0, l_addr = 32'h0, l_wdata = 32'h0;
    logic [2:0]  c_ctrl = 3'd2, l_ctrl = 3'd5;
    logic        c_gnt, c_stall, l_gnt, mem_we;
    logic [31:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem [0:255];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata), .c_ctrl_i(c_ctrl),
        .c_gnt_o(c_gnt), .c_rdata_o(c_rdata), .c_stall_o(c_stall),
        .l_req_i(l_req), .l_lock_i(l_lock), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_ctrl_i(l_ctrl), .l_gnt_o(l_gnt), .l_rdata_o(l_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ctrl_o(mem_ctrl), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    // Simple word memory: combinational read, write on the edge ending a granted cycle.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: every cycle carries an output, compare it with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("c_gnt", {31'h0, c_gnt}, {31'h0, e.cg});
            chk("l_gnt", {31'h0, l_gnt}, {31'h0, e.lg});
            chk("c_stall", {31'h0, c_stall}, {31'h0, e.st});
            chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("mem_ctrl", {29'h0, mem_ctrl}, {29'h0, e.ctrl});
            if (e.chk_rd) chk("c_rdata", c_rdata, e.rd);
        end
    end

    task automatic vec(input logic r, input logic creq, input logic cwe, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic lreq, input logic llock, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd, input logic ecg, input logic elg,
                       input logic erd_chk, input logic [31:0] erd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; c_req = creq; c_we = cwe; c_addr = ca; c_wdata = cwd;
        l_req = lreq; l_lock = llock; l_we = lwe; l_addr = la; l_wdata = lwd;
        e.cg = ecg;
        e.lg = elg;
        e.st = creq & ~ecg & ~r;
        e.we = elg ? lwe : (ecg ? cwe : 1'b0);
        e.addr = elg ? la : (ecg ? ca : 32'h0);
        e.wdata = elg ? lwd : (ecg ? cwd : 32'h0);
        e.ctrl = elg ? l_ctrl : (ecg ? c_ctrl : 3'd0);
        e.chk_rd = erd_chk;
        e.rd = erd;
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset with both requesting writes: nothing granted, nothing written.
        repeat (2) vec(1'b1, 1'b1, 1'b1, 32'h10, 32'h1111, 1'b1, 1'b0, 1'b1, 32'h20, 32'h2222, 1'b0, 1'b0, 1'b0, 32'h0);
        // Ties alternate starting with C.
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Solo loader write, core readback.
        vec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);

        // Full lock burst: L for 8, C through the refused cycle and the backoff cycle.
        repeat (8) vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);

        // Lock for 3 then drop: tie goes to C, then back to L with no lock.
        repeat (3) vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Locked write burst, reset asserted mid-cycle at cnt=5.
        for (int k = 0; k < 5; k++)
            vec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hA1 + 32'(k), 1'b0, 1'b1, 1'b0, 32'h0);
        vec(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        vec(1'b0, 1'b1, 1'b0, 32'h110, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA5);
        vec(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA1);

        for (int n = 0; n < 8 && exp_q.size() > 0; n++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
